// File: rtl/nibble_serial_add_sub_pkg.sv
// nibble_serial_add_sub_pkg
// Shared definitions for the nibble-serial adder/subtractor:
//   state_t   - FSM state encoding (IDLE / CALC / DONE)
//   NIBBLE_W  - width of one slice of the serial datapath
package nibble_serial_add_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_sub_slice.sv
// nibble_add_sub_slice
// Purely combinational 4-bit add/sub slice. B is inverted inside the slice
// when sub=1, so the caller only has to supply cin=1 for the first nibble of
// a subtraction.
// Ports:
//   a, b  in   nibble operands
//   sub   in   0 = add, 1 = subtract (inverts b)
//   cin   in   carry in
//   s     out  nibble sum
//   cout  out  carry out of bit 3
//   c3    out  carry into bit 3 (used for signed overflow on the top nibble)
module nibble_add_sub_slice
    import nibble_serial_add_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W-1:0] b_x;

    // The add is split at bit 3 so the carry into the MSB is visible for
    // the overflow calculation.
    always_comb begin
        b_x           = b ^ {NIBBLE_W{sub}};
        {c3, s[2:0]}  = {1'b0, a[2:0]} + {1'b0, b_x[2:0]} + {3'b000, cin};
        {cout, s[3]}  = {1'b0, a[3]} + {1'b0, b_x[3]} + {1'b0, c3};
    end

endmodule

// File: rtl/nibble_serial_add_sub.sv
// nibble_serial_add_sub
// Multi-cycle WIDTH-bit adder/subtractor built from one 4-bit slice that is
// reused once per clock, least-significant nibble first. A start/busy/done
// handshake lets a controller issue wide operations without a wide carry chain.
// Ports:
//   clk      in   system clock, rising edge
//   reset_p  in   synchronous active-high reset
//   start    in   request, accepted in IDLE or DONE
//   sub      in   0 = a+b, 1 = a-b (captured with start)
//   a, b     in   WIDTH-bit operands (captured with start)
//   busy     out  high while calculating
//   done     out  one-cycle pulse when result/flags update
//   result   out  sum or difference modulo 2^WIDTH
//   c_flag   out  add: carry out, sub: borrow (a < b unsigned)
//   v_flag   out  signed overflow
//   z_flag   out  result == 0
module nibble_serial_add_sub
    import nibble_serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             v_flag,
    output logic             z_flag
);

    localparam int NUM_NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W       = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

    state_t                      state;
    state_t                      state_next;
    logic [IDX_W-1:0]            idx;
    logic [WIDTH-1:0]            a_sh;
    logic [WIDTH-1:0]            b_sh;
    logic                        sub_r;
    logic                        carry_r;
    logic [WIDTH-NIBBLE_W-1:0]   shadow;
    logic [WIDTH-1:0]            shadow_next;
    logic [NIBBLE_W-1:0]         slice_s;
    logic                        slice_cout;
    logic                        slice_c3;
    logic                        accept;
    logic                        last_nibble;

    nibble_add_sub_slice u_slice (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .sub  (sub_r),
        .cin  (carry_r),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    // A start is only honoured when no calculation is in flight; DONE counts
    // as free so back-to-back operations lose no cycle.
    assign accept      = start && ((state == IDLE) || (state == DONE));
    assign last_nibble = (idx == LAST_IDX);

    // The shadow holds only the nibbles already finished; the new nibble
    // enters at the top, so after the last nibble the concatenation is the
    // complete result in the right bit positions.
    assign shadow_next = {slice_s, shadow};

    // State register.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? CALC : IDLE;
            CALC:    state_next = last_nibble ? DONE : CALC;
            DONE:    state_next = accept ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // Serial datapath: capture on accept, then one nibble per CALC cycle.
    // Result and flags only change on the last nibble so they hold across a
    // new start until that operation completes.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            idx     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            shadow  <= '0;
            result  <= '0;
            c_flag  <= 1'b0;
            v_flag  <= 1'b0;
            z_flag  <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            a_sh    <= a;
            b_sh    <= b;
            sub_r   <= sub;
            carry_r <= sub;
            shadow  <= '0;
        end else if (state == CALC) begin
            idx     <= idx + 1'b1;
            a_sh    <= a_sh >> NIBBLE_W;
            b_sh    <= b_sh >> NIBBLE_W;
            carry_r <= slice_cout;
            shadow  <= shadow_next[WIDTH-1:NIBBLE_W];
            if (last_nibble) begin
                result <= shadow_next;
                c_flag <= slice_cout ^ sub_r;
                v_flag <= slice_c3 ^ slice_cout;
                z_flag <= (shadow_next == '0);
            end
        end
    end

endmodule
